burrito_fetch: RTL and testbench

Instruction fetch stage for the Burrito datapath. It runs a program counter over the asynchronous instruction RAM and latches each 20-bit instruction word into an output register. It presents each word downstream with a valid/ready handshake, split into its WEnable/Op/D1/D2/RD fields. It replaces bench-driven instruction sequencing: after a `start` pulse it walks addresses 0..PROG_LEN-1 and then signals `done`.

---
 rtl/burrito_pkg.sv | 27 ++
 rtl/burrito_fetch.sv | 148 ++++++++++++++
 tb/tb_burrito_fetch.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burrito_pkg.sv
// Shared definitions for the Burrito fetch stage: instruction word layout,
// the halt opcode and the fetch state encoding.
package burrito_pkg;

    localparam int INSTR_W = 20;

    // Instruction field bit positions
    localparam int WE_BIT  = 19;
    localparam int OP_MSB  = 18;
    localparam int OP_LSB  = 15;
    localparam int D1_MSB  = 14;
    localparam int D1_LSB  = 10;
    localparam int D2_MSB  = 9;
    localparam int D2_LSB  = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 0;

    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/burrito_fetch.sv
// Burrito instruction fetch stage.
// Walks a PC over an asynchronous instruction RAM after a start pulse,
// latches each word into an output register and presents it downstream
// with a valid/ready handshake, split into WEnable/Op/D1/D2/RD fields.
// Optional feature: define BURRITO_FETCH_HALT_EN to stop the run on the
// first word whose opcode is OP_HALT (that word is never presented).
module burrito_fetch #(
    parameter int ADDR_W   = 3,
    parameter int INSTR_W  = burrito_pkg::INSTR_W,
    parameter int PROG_LEN = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_we,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               wenable,
    output logic [3:0]         op,
    output logic [4:0]         d1,
    output logic [4:0]         d2,
    output logic [4:0]         rd,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               busy,
    output logic               done
);

    import burrito_pkg::*;

    // Address of the final word of a run; the PC parks here instead of wrapping.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

    fetch_state_e         state_r;
    fetch_state_e         state_nxt_s;
    logic [ADDR_W-1:0]    pc_r;
    logic [ADDR_W-1:0]    pc_nxt_s;
    logic [INSTR_W-1:0]   instr_r;
    logic [INSTR_W-1:0]   instr_nxt_s;
    logic                 valid_r;
    logic                 valid_nxt_s;
    logic                 busy_r;
    logic                 done_r;
    logic                 load_s;
    logic                 xfer_s;
    logic                 halt_s;

    // The output register can take a new word when it is empty or being drained.
    assign load_s = !valid_r || instr_ready;
    assign xfer_s = valid_r && instr_ready;

`ifdef BURRITO_FETCH_HALT_EN
    assign halt_s = (imem_data[OP_MSB:OP_LSB] == OP_HALT);
`else
    assign halt_s = 1'b0;
`endif

    // Next-state, next-PC and output-word selection.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
        valid_nxt_s = valid_r;
        case (state_r)
            IDLE: begin
                pc_nxt_s    = '0;
                valid_nxt_s = 1'b0;
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (halt_s) begin
                    // Halt word is dropped; a pending word must still drain.
                    if (valid_r && !instr_ready) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        valid_nxt_s = 1'b0;
                        state_nxt_s = DONE;
                    end
                end else if (load_s) begin
                    instr_nxt_s = imem_data;
                    valid_nxt_s = 1'b1;
                    if (pc_r == LAST_ADDR) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        pc_nxt_s = pc_r + ADDR_W'(1);
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (xfer_s) begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                pc_nxt_s    = '0;
                valid_nxt_s = 1'b0;
                state_nxt_s = IDLE;
            end
            default: begin
                pc_nxt_s    = '0;
                valid_nxt_s = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, PC, output word and status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pc_r    <= '0;
            instr_r <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            instr_r <= instr_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    assign imem_addr   = pc_r;
    assign imem_we     = 1'b0;
    assign instr       = instr_r;
    assign wenable     = instr_r[WE_BIT];
    assign op          = instr_r[OP_MSB:OP_LSB];
    assign d1          = instr_r[D1_MSB:D1_LSB];
    assign d2          = instr_r[D2_MSB:D2_LSB];
    assign rd          = instr_r[RD_MSB:RD_LSB];
    assign instr_valid = valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_burrito_fetch.sv
// Self-checking bench for burrito_fetch: decode table, directed corner-case
// sequences and randomized runs against a transfer-list reference model.
module tb_burrito_fetch;

    localparam int ADDR_W   = 3;
    localparam int INSTR_W  = 20;
    localparam int PROG_LEN = 6;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_we;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               wenable;
    logic [3:0]         op;
    logic [4:0]         d1;
    logic [4:0]         d2;
    logic [4:0]         rd;
    logic               instr_valid;
    logic               instr_ready;
    logic               busy;
    logic               done;

    logic [INSTR_W-1:0] mem [0:7];
    logic [INSTR_W-1:0] exp_w [0:7];
    logic [INSTR_W-1:0] cap_w [0:7];
    logic               cap_we [0:7];
    logic [3:0]         cap_op [0:7];
    logic [4:0]         cap_d1 [0:7];
    logic [4:0]         cap_d2 [0:7];
    logic [4:0]         cap_rd [0:7];

    int n_cmp;
    int n_bad;
    int last_got;

    typedef struct {
        logic [19:0] w;
        logic        we;
        logic [3:0]  op;
        logic [4:0]  d1;
        logic [4:0]  d2;
        logic [4:0]  rd;
    } vec_t;

    vec_t tbl [0:5];

    assign imem_data = mem[imem_addr];

    burrito_fetch #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .PROG_LEN (PROG_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_we     (imem_we),
        .imem_data   (imem_data),
        .instr       (instr),
        .wenable     (wenable),
        .op          (op),
        .d1          (d1),
        .d2          (d2),
        .rd          (rd),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event, expected one within the cycle budget", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full run. mode 0: ready high; 1: random ready and start;
    // 2: three-cycle stall while word 2 is valid; 3: start held high throughout.
    task automatic do_run(input int mode);
        int  exp_n;
        int  got;
        int  done_cyc;
        int  last_xfer;
        int  stall_left;
        bit  stalled;
        bit  stop;
        logic pv, pr, pwe;
        logic [19:0] pi;
        logic [3:0]  pop;
        logic [4:0]  pd1, pd2, prd;

        // Reference: the words transferred are the program in address order,
        // cut short at the first halt opcode when halting is enabled.
        exp_n = 0;
        stop  = 1'b0;
        for (int a = 0; a < PROG_LEN; a++) begin
`ifdef BURRITO_FETCH_HALT_EN
            if (((mem[a] >> 15) & 20'hF) == 20'hF) stop = 1'b1;
`endif
            if (!stop) begin
                exp_w[exp_n] = mem[a];
                exp_n++;
            end
        end

        start       = 1'b1;
        instr_ready = 1'b1;
        step();
        start = (mode == 3) ? 1'b1 : 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("valid_after_start", {31'd0, instr_valid}, 32'd0);

        got        = 0;
        done_cyc   = -1;
        last_xfer  = -1;
        stall_left = 0;
        stalled    = 1'b0;
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            case (mode)
                1: begin
                    instr_ready = 1'($urandom_range(0, 1));
                    start       = 1'($urandom_range(0, 1));
                end
                2: begin
                    if (!stalled && got == 2 && instr_valid) begin
                        stalled    = 1'b1;
                        stall_left = 3;
                    end
                    if (stall_left > 0) begin
                        instr_ready = 1'b0;
                        stall_left--;
                    end else begin
                        instr_ready = 1'b1;
                    end
                end
                default: instr_ready = 1'b1;
            endcase
            pv = instr_valid; pr = instr_ready; pi = instr;
            pwe = wenable; pop = op; pd1 = d1; pd2 = d2; prd = rd;
            step();
            if (pv && pr) begin
                if (got < exp_n) begin
                    chk("xfer_word", {12'd0, pi}, {12'd0, exp_w[got]});
                    chk("xfer_op", {28'd0, pop}, 32'((exp_w[got] >> 15) & 20'hF));
                    chk("xfer_rd", {27'd0, prd}, 32'(exp_w[got] & 20'h1F));
                    cap_w[got] = pi; cap_we[got] = pwe; cap_op[got] = pop;
                    cap_d1[got] = pd1; cap_d2[got] = pd2; cap_rd[got] = prd;
                end else begin
                    chk("extra_xfer", 32'(got + 1), 32'(exp_n));
                end
                got++;
                last_xfer = cyc;
            end
            if (pv && !pr) begin
                chk("hold_instr", {12'd0, instr}, {12'd0, pi});
                chk("hold_valid", {31'd0, instr_valid}, 32'd1);
                if (mode == 2) begin
                    chk("stall_pc", {29'd0, imem_addr}, 32'd3);
                    chk("stall_word", {12'd0, instr}, {12'd0, exp_w[2]});
                end
            end
            if (done) begin
                done_cyc = cyc;
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
        if (done_cyc < 0) fail_now("run_timeout");

        step();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_addr", {29'd0, imem_addr}, 32'd0);
        chk("idle_valid", {31'd0, instr_valid}, 32'd0);
        start = 1'b0;
        step();
        chk("still_idle", {31'd0, busy}, 32'd0);
        chk("xfer_count", 32'(got), 32'(exp_n));
        if (exp_n > 0) chk("done_after_last_xfer", 32'(done_cyc), 32'(last_xfer));
        if (mode == 0 || mode == 3) chk("full_speed_latency", 32'(done_cyc), 32'(exp_n + 1));
        if (mode == 2) chk("stall_happened", {31'd0, stalled}, 32'd1);
        last_got = got;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tbl[0] = '{20'h5A5A5, 1'b0, 4'hB, 5'h09, 5'h0D, 5'h05};
        tbl[1] = '{20'hA5A5A, 1'b1, 4'h4, 5'h16, 5'h12, 5'h1A};
        tbl[2] = '{20'h00000, 1'b0, 4'h0, 5'h00, 5'h00, 5'h00};
        tbl[3] = '{20'hBFFFF, 1'b1, 4'h7, 5'h1F, 5'h1F, 5'h1F};
        tbl[4] = '{20'h12345, 1'b0, 4'h2, 5'h08, 5'h1A, 5'h05};
        tbl[5] = '{20'h80006, 1'b1, 4'h0, 5'h00, 5'h00, 5'h06};

        for (int a = 0; a < 8; a++) mem[a] = 20'h80001 + 20'(a);
        rst_n       = 1'b0;
        start       = 1'b0;
        instr_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", {12'd0, instr}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", {29'd0, imem_addr}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_fields", {13'd0, wenable, op, d1, d2, rd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_hold_busy", {31'd0, busy}, 32'd0);
            chk("idle_hold_addr", {29'd0, imem_addr}, 32'd0);
            chk("idle_hold_valid", {31'd0, instr_valid}, 32'd0);
        end

        // Full-speed run, backpressure, start ignored while busy
        do_run(0);
        do_run(2);
        do_run(3);

        // Reset mid-run after word 3 is issued
        start = 1'b1; instr_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("pre_reset_word3", {12'd0, instr}, {12'd0, mem[3]});
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_instr", {12'd0, instr}, 32'd0);
        chk("midrst_addr", {29'd0, imem_addr}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_run(0);
        chk("refetch_word0", {12'd0, cap_w[0]}, {12'd0, mem[0]});

        // Decode table
        for (int i = 0; i < 6; i++) mem[i] = tbl[i].w;
        do_run(0);
        for (int i = 0; i < 6; i++) begin
            chk("tbl_word", {12'd0, cap_w[i]}, {12'd0, tbl[i].w});
            chk("tbl_we", {31'd0, cap_we[i]}, {31'd0, tbl[i].we});
            chk("tbl_op", {28'd0, cap_op[i]}, {28'd0, tbl[i].op});
            chk("tbl_d1", {27'd0, cap_d1[i]}, {27'd0, tbl[i].d1});
            chk("tbl_d2", {27'd0, cap_d2[i]}, {27'd0, tbl[i].d2});
            chk("tbl_rd", {27'd0, cap_rd[i]}, {27'd0, tbl[i].rd});
        end

        // Halt word at address 3
        for (int a = 0; a < 8; a++) mem[a] = 20'h80001 + 20'(a);
        mem[3] = 20'h78000;
        do_run(0);
`ifdef BURRITO_FETCH_HALT_EN
        chk("halt_count", 32'(last_got), 32'd3);
`else
        chk("halt_word_presented", {12'd0, cap_w[3]}, 32'h78000);
`endif

        // Randomized programs and handshake
        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < 8; a++) begin
                mem[a] = 20'($urandom);
                if ($urandom_range(0, 7) == 0) mem[a][18:15] = 4'hF;
            end
            do_run(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
